miriscv_gpr_wb_arb: RTL and testbench

//  Writeback arbiter and load scoreboard in front of the miriscv GPR single write port.

---
 rtl/miriscv_gpr_wb_arb_pkg.sv | 23 ++
 rtl/miriscv_gpr_wb_arb_if.sv | 43 ++++
 rtl/miriscv_wb_fifo.sv | 46 ++++
 rtl/miriscv_gpr_wb_arb.sv | 104 ++++++++++
 tb/tb_miriscv_gpr_wb_arb.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/miriscv_gpr_wb_arb_pkg.sv
// Shared types for the GPR writeback arbiter: widths, source select enum, buffered entry.
package miriscv_gpr_wb_arb_pkg;

  localparam int XLEN           = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int NUM_GPR        = 2 ** GPR_ADDR_WIDTH;

  typedef logic [GPR_ADDR_WIDTH-1:0] gpr_addr_t;
  typedef logic [XLEN-1:0]           xlen_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_LSU_FIFO,
    WB_SRC_LSU_BYP
  } wb_src_e;

  typedef struct packed {
    gpr_addr_t addr;
    xlen_t     data;
  } wb_entry_t;

endpackage

// File: rtl/miriscv_gpr_wb_arb_if.sv
// Writeback arbiter bundle: ALU/LSU result inputs, load scoreboard, GPR write port.
// master = core side driving results and decode lookups, slave = the arbiter.
interface miriscv_gpr_wb_arb_if #(
  parameter int LSU_FIFO_DEPTH = 4
);
  import miriscv_gpr_wb_arb_pkg::*;

  logic                            alu_wb_valid_i;
  gpr_addr_t                       alu_wb_addr_i;
  xlen_t                           alu_wb_data_i;
  logic                            lsu_wb_valid_i;
  logic                            lsu_wb_ready_o;
  gpr_addr_t                       lsu_wb_addr_i;
  xlen_t                           lsu_wb_data_i;
  logic                            load_issue_i;
  gpr_addr_t                       load_issue_rd_i;
  gpr_addr_t                       r1_addr_i;
  gpr_addr_t                       r2_addr_i;
  logic                            r1_busy_o;
  logic                            r2_busy_o;
  logic [NUM_GPR-1:0]              busy_o;
  logic [$clog2(LSU_FIFO_DEPTH):0] lsu_fifo_level_o;
  logic                            gpr_wr_en_o;
  gpr_addr_t                       gpr_wr_addr_o;
  xlen_t                           gpr_wr_data_o;

  modport master (
    output alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i,
    output lsu_wb_valid_i, lsu_wb_addr_i, lsu_wb_data_i,
    output load_issue_i, load_issue_rd_i, r1_addr_i, r2_addr_i,
    input  lsu_wb_ready_o, r1_busy_o, r2_busy_o, busy_o, lsu_fifo_level_o,
    input  gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o
  );

  modport slave (
    input  alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i,
    input  lsu_wb_valid_i, lsu_wb_addr_i, lsu_wb_data_i,
    input  load_issue_i, load_issue_rd_i, r1_addr_i, r2_addr_i,
    output lsu_wb_ready_o, r1_busy_o, r2_busy_o, busy_o, lsu_fifo_level_o,
    output gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o
  );

endinterface

// File: rtl/miriscv_wb_fifo.sv
// Sync FIFO of writeback entries; head visible same cycle, one-cycle push-to-head.
// Push is ignored when full and pop when empty; caller gates with full/empty.
module miriscv_wb_fifo
  import miriscv_gpr_wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     push_vld,
  input  wb_entry_t                push_dat,
  input  logic                     pop_vld,
  output wb_entry_t                head_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  wb_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LVL);
  assign empty    = (wr_ptr == rd_ptr);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_vld && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/miriscv_gpr_wb_arb.sv
// GPR writeback arbiter (ALU > buffered LSU > LSU bypass), 0-cycle select, plus load scoreboard.
// LSU is back-pressured by a registered FIFO-full; the ALU path never stalls.
module miriscv_gpr_wb_arb
  import miriscv_gpr_wb_arb_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 4
) (
  input logic                 clk_i,
  input logic                 arstn_i,
  miriscv_gpr_wb_arb_if.slave bus
);

  wb_entry_t                        alu_ent;
  wb_entry_t                        lsu_ent;
  wb_entry_t                        fifo_head;
  wb_entry_t                        sel_ent;
  wb_src_e                          src;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [$clog2(LSU_FIFO_DEPTH):0]  fifo_level;
  logic                             lsu_acc;
  logic                             lsu_commit;
  logic                             push;
  logic                             pop;
  logic [NUM_GPR-1:0]               busy_q;
  logic [NUM_GPR-1:0]               busy_d;
  logic [NUM_GPR-1:0]               set_mask;
  logic [NUM_GPR-1:0]               clr_mask;

  assign alu_ent = '{addr: bus.alu_wb_addr_i, data: bus.alu_wb_data_i};
  assign lsu_ent = '{addr: bus.lsu_wb_addr_i, data: bus.lsu_wb_data_i};

  assign bus.lsu_wb_ready_o = !fifo_full;
  assign lsu_acc            = bus.lsu_wb_valid_i && !fifo_full;

  // Bypass only with an empty FIFO, so LSU results retire in acceptance order.
  always_comb begin
    src     = WB_SRC_NONE;
    sel_ent = '0;
    if (bus.alu_wb_valid_i) begin
      src     = WB_SRC_ALU;
      sel_ent = alu_ent;
    end else if (!fifo_empty) begin
      src     = WB_SRC_LSU_FIFO;
      sel_ent = fifo_head;
    end else if (lsu_acc) begin
      src     = WB_SRC_LSU_BYP;
      sel_ent = lsu_ent;
    end
  end

  assign pop        = (src == WB_SRC_LSU_FIFO);
  assign push       = lsu_acc && (src != WB_SRC_LSU_BYP);
  assign lsu_commit = (src == WB_SRC_LSU_FIFO) || (src == WB_SRC_LSU_BYP);

  assign bus.gpr_wr_en_o   = arstn_i && (src != WB_SRC_NONE) && (sel_ent.addr != '0);
  assign bus.gpr_wr_addr_o = sel_ent.addr;
  assign bus.gpr_wr_data_o = sel_ent.data;

  miriscv_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .push_vld (push),
    .push_dat (lsu_ent),
    .pop_vld  (pop),
    .head_dat (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.lsu_fifo_level_o = fifo_level;

  // A new load to the register being retired this cycle keeps it busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.load_issue_i) set_mask[bus.load_issue_rd_i] = 1'b1;
    if (lsu_commit)       clr_mask[sel_ent.addr]        = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign bus.busy_o    = busy_q;
  assign bus.r1_busy_o = busy_q[bus.r1_addr_i];
  assign bus.r2_busy_o = busy_q[bus.r2_addr_i];

  a_no_waw_issue: assert property (@(posedge clk_i) disable iff (!arstn_i)
    (bus.load_issue_i && bus.load_issue_rd_i != '0) |-> !busy_q[bus.load_issue_rd_i]);

  a_no_alu_to_busy: assert property (@(posedge clk_i) disable iff (!arstn_i)
    (bus.alu_wb_valid_i && bus.alu_wb_addr_i != '0) |-> !busy_q[bus.alu_wb_addr_i]);

  a_lsu_rd_busy: assert property (@(posedge clk_i) disable iff (!arstn_i)
    (lsu_acc && bus.lsu_wb_addr_i != '0) |-> busy_q[bus.lsu_wb_addr_i]);

endmodule

// File: tb/tb_miriscv_gpr_wb_arb.sv
// Bench for the writeback arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_miriscv_gpr_wb_arb;
  import miriscv_gpr_wb_arb_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  miriscv_gpr_wb_arb_if #(.LSU_FIFO_DEPTH(D)) wb ();

  miriscv_gpr_wb_arb #(.LSU_FIFO_DEPTH(D)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (wb)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: scoreboard bits and the ordered list of accepted-but-unwritten loads.
  logic [NUM_GPR-1:0] m_busy = '0;
  wb_entry_t          m_q[$];
  logic               m_took = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb.alu_wb_valid_i  = 1'b0;
    wb.alu_wb_addr_i   = '0;
    wb.alu_wb_data_i   = '0;
    wb.lsu_wb_valid_i  = 1'b0;
    wb.lsu_wb_addr_i   = '0;
    wb.lsu_wb_data_i   = '0;
    wb.load_issue_i    = 1'b0;
    wb.load_issue_rd_i = '0;
    wb.r1_addr_i       = '0;
    wb.r2_addr_i       = '0;
  endtask

  task automatic set_alu(input logic v, input gpr_addr_t a, input xlen_t d);
    wb.alu_wb_valid_i = v; wb.alu_wb_addr_i = a; wb.alu_wb_data_i = d;
  endtask

  task automatic set_lsu(input logic v, input gpr_addr_t a, input xlen_t d);
    wb.lsu_wb_valid_i = v; wb.lsu_wb_addr_i = a; wb.lsu_wb_data_i = d;
  endtask

  task automatic set_issue(input logic v, input gpr_addr_t rd);
    wb.load_issue_i = v; wb.load_issue_rd_i = rd;
  endtask

  // Compare every output against the model for the current inputs, then advance the model.
  task automatic model_cmp();
    logic      rdy, acc, vld, lsu_path, byp;
    wb_entry_t sel;
    if (!arstn) begin
      m_busy = '0;
      m_q.delete();
      m_took = 1'b0;
      chk("rst_level", 64'(wb.lsu_fifo_level_o), 64'd0);
      chk("rst_busy",  64'(wb.busy_o), 64'd0);
      chk("rst_wr_en", 64'(wb.gpr_wr_en_o), 64'd0);
      chk("rst_ready", 64'(wb.lsu_wb_ready_o), 64'd1);
      return;
    end
    rdy      = (m_q.size() < D);
    acc      = wb.lsu_wb_valid_i && rdy;
    vld      = 1'b1;
    lsu_path = 1'b0;
    byp      = 1'b0;
    sel      = '0;
    if (wb.alu_wb_valid_i) begin
      sel = '{addr: wb.alu_wb_addr_i, data: wb.alu_wb_data_i};
    end else if (m_q.size() > 0) begin
      sel = m_q[0];
      lsu_path = 1'b1;
    end else if (acc) begin
      sel = '{addr: wb.lsu_wb_addr_i, data: wb.lsu_wb_data_i};
      lsu_path = 1'b1;
      byp = 1'b1;
    end else begin
      vld = 1'b0;
    end
    chk("ready",   64'(wb.lsu_wb_ready_o), 64'(rdy));
    chk("level",   64'(wb.lsu_fifo_level_o), 64'(m_q.size()));
    chk("busy",    64'(wb.busy_o), 64'(m_busy));
    chk("r1_busy", 64'(wb.r1_busy_o), 64'(m_busy[wb.r1_addr_i]));
    chk("r2_busy", 64'(wb.r2_busy_o), 64'(m_busy[wb.r2_addr_i]));
    chk("wr_en",   64'(wb.gpr_wr_en_o), 64'(vld && sel.addr != '0));
    if (vld && sel.addr != '0) begin
      chk("wr_addr", 64'(wb.gpr_wr_addr_o), 64'(sel.addr));
      chk("wr_data", 64'(wb.gpr_wr_data_o), 64'(sel.data));
    end
    if (lsu_path && !byp) void'(m_q.pop_front());
    if (acc && !byp) m_q.push_back('{addr: wb.lsu_wb_addr_i, data: wb.lsu_wb_data_i});
    if (lsu_path && sel.addr != '0) m_busy[sel.addr] = 1'b0;
    if (wb.load_issue_i && wb.load_issue_rd_i != '0) m_busy[wb.load_issue_rd_i] = 1'b1;
    m_took = acc;
  endtask

  task automatic sample();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  initial begin
    xlen_t     seen[$];
    gpr_addr_t pend[$];
    int        k;
    idle();
    // Reset asserted
    sample();
    adv();
    arstn = 1'b1;

    // 1: reset release
    sample();
    chk("t1_busy",  64'(wb.busy_o), 64'd0);
    chk("t1_ready", 64'(wb.lsu_wb_ready_o), 64'd1);
    chk("t1_level", 64'(wb.lsu_fifo_level_o), 64'd0);
    chk("t1_wr_en", 64'(wb.gpr_wr_en_o), 64'd0);
    adv();

    // 2: lone ALU write
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    sample();
    chk("t2_wr_en", 64'(wb.gpr_wr_en_o), 64'd1);
    chk("t2_addr",  64'(wb.gpr_wr_addr_o), 64'd5);
    chk("t2_data",  64'(wb.gpr_wr_data_o), 64'hDEADBEEF);
    adv();
    idle();

    // 3: ALU and LSU collide; LSU result buffered one cycle
    set_issue(1'b1, 5'd7);
    step();
    idle();
    set_alu(1'b1, 5'd3, 32'd1);
    set_lsu(1'b1, 5'd7, 32'h55);
    sample();
    chk("t3_c0_addr",  64'(wb.gpr_wr_addr_o), 64'd3);
    chk("t3_c0_data",  64'(wb.gpr_wr_data_o), 64'd1);
    chk("t3_c0_busy7", 64'(wb.busy_o[7]), 64'd1);
    adv();
    idle();
    sample();
    chk("t3_c1_wr_en", 64'(wb.gpr_wr_en_o), 64'd1);
    chk("t3_c1_addr",  64'(wb.gpr_wr_addr_o), 64'd7);
    chk("t3_c1_data",  64'(wb.gpr_wr_data_o), 64'h55);
    chk("t3_c1_level", 64'(wb.lsu_fifo_level_o), 64'd1);
    chk("t3_c1_busy7", 64'(wb.busy_o[7]), 64'd1);
    adv();
    sample();
    chk("t3_c2_level", 64'(wb.lsu_fifo_level_o), 64'd0);
    chk("t3_c2_busy7", 64'(wb.busy_o[7]), 64'd0);
    adv();

    // 4: fill the FIFO under ALU pressure, then drain in order
    for (int i = 0; i < 6; i++) begin
      set_issue(1'b1, gpr_addr_t'(11 + i));
      step();
    end
    idle();
    k = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 6) set_alu(1'b1, 5'd1, xlen_t'(c));
      else       set_alu(1'b0, '0, '0);
      if (k < 6) set_lsu(1'b1, gpr_addr_t'(11 + k), xlen_t'(k + 1));
      else       set_lsu(1'b0, '0, '0);
      sample();
      if (c == 4) chk("t4_ready_low", 64'(wb.lsu_wb_ready_o), 64'd0);
      if (wb.gpr_wr_en_o && wb.gpr_wr_addr_o >= 5'd11 && wb.gpr_wr_addr_o <= 5'd16) begin
        seen.push_back(wb.gpr_wr_data_o);
        if (wb.gpr_wr_data_o == 32'd5)
          chk("t4_5_via_fifo", 64'(wb.lsu_fifo_level_o != '0), 64'd1);
      end
      if (m_took) k++;
      adv();
    end
    idle();
    chk("t4_count", 64'(seen.size()), 64'd6);
    for (int j = 0; j < seen.size(); j++) chk("t4_order", 64'(seen[j]), 64'(j + 1));

    // 5: x0 load and scoreboard lookup
    set_issue(1'b1, 5'd0);
    step();
    set_issue(1'b1, 5'd10);
    step();
    idle();
    set_lsu(1'b1, 5'd0, 32'h1234);
    wb.r1_addr_i = 5'd10;
    sample();
    chk("t5_busy0",   64'(wb.busy_o[0]), 64'd0);
    chk("t5_wr_en",   64'(wb.gpr_wr_en_o), 64'd0);
    chk("t5_ready",   64'(wb.lsu_wb_ready_o), 64'd1);
    chk("t5_r1_busy", 64'(wb.r1_busy_o), 64'd1);
    adv();
    idle();
    sample();
    chk("t5_consumed", 64'(wb.lsu_fifo_level_o), 64'd0);
    adv();
    set_lsu(1'b1, 5'd10, 32'd7);
    step();
    idle();
    step();

    // 6: asynchronous reset with a partly filled FIFO
    for (int i = 0; i < 3; i++) begin
      set_issue(1'b1, gpr_addr_t'(9 + i));
      step();
    end
    idle();
    set_alu(1'b1, 5'd1, 32'hA5A5);
    for (int i = 0; i < 3; i++) begin
      set_lsu(1'b1, gpr_addr_t'(9 + i), xlen_t'(100 + i));
      step();
    end
    set_lsu(1'b0, '0, '0);
    sample();
    chk("t6_pre_level", 64'(wb.lsu_fifo_level_o), 64'd3);
    chk("t6_pre_busy",  64'(wb.busy_o[11:9]), 64'h7);
    adv();
    #2;
    arstn = 1'b0;
    idle();
    #1;
    chk("t6_level", 64'(wb.lsu_fifo_level_o), 64'd0);
    chk("t6_busy",  64'(wb.busy_o), 64'd0);
    chk("t6_wr_en", 64'(wb.gpr_wr_en_o), 64'd0);
    sample();
    adv();
    #2;
    arstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t6_no_stale", 64'(wb.gpr_wr_en_o), 64'd0);
      adv();
    end

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      logic      iss;
      gpr_addr_t rd;
      gpr_addr_t a;
      iss = 1'b0;
      rd  = '0;
      if (!wb.lsu_wb_valid_i && pend.size() > 0 && $urandom_range(0, 2) != 0)
        set_lsu(1'b1, pend[0], xlen_t'($urandom()));
      if (pend.size() < 8 && $urandom_range(0, 2) == 0) begin
        rd  = gpr_addr_t'($urandom_range(0, NUM_GPR - 1));
        iss = 1'b1;
        if (rd != '0) begin
          if (m_busy[rd]) iss = 1'b0;
          foreach (pend[p]) if (pend[p] == rd) iss = 1'b0;
        end
      end
      set_issue(iss, rd);
      a = gpr_addr_t'($urandom_range(0, NUM_GPR - 1));
      if (m_busy[a] || (iss && a == rd)) a = '0;
      set_alu(1'($urandom_range(0, 1)), a, xlen_t'($urandom()));
      wb.r1_addr_i = gpr_addr_t'($urandom_range(0, NUM_GPR - 1));
      wb.r2_addr_i = gpr_addr_t'($urandom_range(0, NUM_GPR - 1));
      sample();
      adv();
      if (m_took) begin
        void'(pend.pop_front());
        set_lsu(1'b0, '0, '0);
      end
      if (iss) pend.push_back(rd);
    end

    // Drain remaining loads within a bounded budget
    idle();
    for (int c = 0; c < 200 && (pend.size() > 0 || m_q.size() > 0 || m_busy != '0); c++) begin
      if (!wb.lsu_wb_valid_i && pend.size() > 0)
        set_lsu(1'b1, pend[0], xlen_t'($urandom()));
      sample();
      adv();
      if (m_took) begin
        void'(pend.pop_front());
        set_lsu(1'b0, '0, '0);
      end
    end
    idle();
    sample();
    chk("drain_busy",  64'(wb.busy_o), 64'd0);
    chk("drain_level", 64'(wb.lsu_fifo_level_o), 64'd0);
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
